// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer: round, shift and saturate a 32-bit FIR output to 16 bits over a two-stage AXI-Stream pipeline
module fir_output_quantizer #(
  parameter int SHIFT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic signed [31:0] ss_i_tdata,
  input  logic               ss_i_tvalid,
  input  logic               ss_i_tlast,
  output logic               ss_o_tready,
  output logic signed [15:0] ms_o_tdata,
  output logic               ms_o_tvalid,
  output logic               ms_o_tlast,
  input  logic               ms_i_tready,
  input  logic               i_sat_clr,
  output logic               o_sat_flag,
  output logic [15:0]        o_sat_count
);
  localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAX = 33'sd32767;
  localparam logic signed [32:0] MIN = -33'sd32768;
  logic               s1_valid;
  logic               s1_last;
  logic signed [32:0] s1_r;
  logic signed [32:0] rnd;
  logic               s2_sat;
  logic               s2_load;
  logic               s1_load;
  logic               hi;
  logic               lo;
  logic signed [15:0] sat_val;
  assign s2_load     = !ms_o_tvalid || ms_i_tready;
  assign s1_load     = !s1_valid || s2_load;
  assign ss_o_tready = i_rst_n && s1_load;
  assign rnd         = ($signed({ss_i_tdata[31], ss_i_tdata}) + HALF) >>> SHIFT;
  // clamp the rounded value into the 16-bit signed range and flag when clamping applied
  always_comb begin
    hi      = s1_r > MAX;
    lo      = s1_r < MIN;
    sat_val = hi ? 16'sh7fff : lo ? 16'sh8000 : s1_r[15:0];
  end
  // stage 1: rounded/shifted intermediate with its frame marker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_r     <= '0;
    end else if (s1_load) begin
      s1_valid <= ss_i_tvalid;
      s1_last  <= ss_i_tlast;
      s1_r     <= rnd;
    end
  end
  // stage 2: saturated output register, held while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ms_o_tvalid <= 1'b0;
      ms_o_tlast  <= 1'b0;
      ms_o_tdata  <= '0;
      s2_sat      <= 1'b0;
    end else if (s2_load) begin
      ms_o_tvalid <= s1_valid;
      if (s1_valid) begin
        ms_o_tlast <= s1_last;
        ms_o_tdata <= sat_val;
        s2_sat     <= hi || lo;
      end
    end
  end
  // saturation statistics, counted on output transfer; clear takes priority
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sat_flag  <= 1'b0;
      o_sat_count <= '0;
    end else if (i_sat_clr) begin
      o_sat_flag  <= 1'b0;
      o_sat_count <= '0;
    end else if (ms_o_tvalid && ms_i_tready && s2_sat) begin
      o_sat_flag <= 1'b1;
      if (o_sat_count != 16'hffff) o_sat_count <= o_sat_count + 16'd1;
    end
  end
endmodule
